bcd_sv_ff: RTL and testbench

BCD_SV_FF -- requirements
Module: bcd_sv_ff

---
 rtl/bcd_pkg.sv | 44 ++++
 rtl/bcd_add3.sv | 24 ++
 rtl/bcd_sv_ff.sv | 159 +++++++++++++++
 tb/tb_bcd_sv_ff.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the binary-to-ASCII-decimal converter:
//   - state_t      : converter FSM states (IDLE, SHIFT, DONE)
//   - BIN_W        : width of the binary input (14)
//   - DIGITS       : number of decimal digits produced (4)
//   - SHIFT_CNT    : number of double-dabble shift cycles (14)
//   - ASCII_ZERO   : ASCII code of '0'
//   - ASCII_SPACE  : ASCII code of ' ' (used for blanked leading zeros)
// Helper functions convert a BCD nibble to ASCII and give the output reset
// word. The reset word depends on the optional macro LEAD_ZERO_BLANK_EN.
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BIN_W     = 14;
  localparam int DIGITS    = 4;
  localparam int SHIFT_CNT = 14;
  localparam int BCD_W     = 4 * DIGITS;
  localparam int CNT_W     = 4;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Map a BCD nibble (0..9) onto its ASCII digit character.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble);
    return ASCII_ZERO + {4'h0, nibble};
  endfunction

  // Value ascii_out takes while reset is applied.
  function automatic logic [8*DIGITS-1:0] reset_word();
`ifdef LEAD_ZERO_BLANK_EN
    return {ASCII_SPACE, ASCII_SPACE, ASCII_SPACE, ASCII_ZERO};
`else
    return {ASCII_ZERO, ASCII_ZERO, ASCII_ZERO, ASCII_ZERO};
`endif
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// One BCD nibble's double-dabble correction: a nibble holding 5 or more gets 3
// added so that the following left shift carries correctly into the next
// decimal digit.
// Ports:
//   nibble   (in,  4) BCD digit before correction
//   adjusted (out, 4) BCD digit after correction
// -----------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  // Conditional add-3 correction.
  always_comb begin
    if (nibble >= 4'd5) begin
      adjusted = nibble + 4'd3;
    end else begin
      adjusted = nibble;
    end
  end

endmodule

// File: rtl/bcd_sv_ff.sv
// -----------------------------------------------------------------------------
// bcd_sv_ff
// Iterative binary-to-ASCII-decimal converter (shift-add-3 / double-dabble).
// One conversion takes 16 clock edges:
//   E0      IDLE  : capture min(bin_in, SAT_VALUE), clear BCD scratch/counter
//   E1..E14 SHIFT : add-3 correction on every nibble, then shift {bcd, bin}
//   E15     DONE  : load ascii_out from the BCD scratch
//   E16           : next capture
// ascii_out is registered and changes only on the DONE edge.
//
// Parameters:
//   SAT_VALUE (default 9999) clamp applied to bin_in before conversion; values
//             above 9999 would not fit in four decimal digits.
// Ports:
//   clk       (in,  1)  clock, rising edge active
//   rst       (in,  1)  synchronous active-high reset
//   bin_in    (in,  14) unsigned binary value, sampled on the capture edge only
//   ascii_out (out, 32) thousands/hundreds/tens/units ASCII, MSB byte first
//
// Build option:
//   LEAD_ZERO_BLANK_EN  when defined, leading zero digits are shown as spaces
//                       (units digit always shown); reset value 0x20202030.
// -----------------------------------------------------------------------------
module bcd_sv_ff
  import bcd_pkg::*;
#(
  parameter int unsigned SAT_VALUE = 9999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [8*DIGITS-1:0]   ascii_out
);

  // Clamp constant, bounded to the input width.
  localparam logic [BIN_W-1:0] SAT_CLAMP =
    (SAT_VALUE > 32'd16383) ? {BIN_W{1'b1}} : BIN_W'(SAT_VALUE);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SHIFT_CNT - 1);

  state_t                   state_r;
  state_t                   state_s;
  logic [BIN_W-1:0]         bin_r;
  logic [BCD_W-1:0]         bcd_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [8*DIGITS-1:0]      ascii_r;

  logic [BIN_W-1:0]         sat_s;
  logic [BCD_W-1:0]         adj_s;
  logic [BCD_W+BIN_W-1:0]   shifted_s;
  logic [8*DIGITS-1:0]      ascii_s;

  // Per-digit add-3 correction of the BCD scratch.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble   (bcd_r[4*g +: 4]),
      .adjusted (adj_s[4*g +: 4])
    );
  end

  // Corrected BCD and the remaining binary bits shift left together; the
  // top bit falling off the end is always zero for in-range values.
  assign shifted_s = {adj_s, bin_r} << 1;

  // Input saturation.
  always_comb begin
    if (bin_in > SAT_CLAMP) begin
      sat_s = SAT_CLAMP;
    end else begin
      sat_s = bin_in;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        state_s = SHIFT;
      end
      SHIFT: begin
        if (cnt_r == LAST_SHIFT) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // BCD scratch to ASCII, with optional leading-zero blanking.
  always_comb begin
    ascii_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ascii_s[8*i +: 8] = nibble_to_ascii(bcd_r[4*i +: 4]);
    end
`ifdef LEAD_ZERO_BLANK_EN
    // A digit is blanked only when it and every digit above it are zero.
    if (bcd_r[15:12] == 4'd0) begin
      ascii_s[31:24] = ASCII_SPACE;
      if (bcd_r[11:8] == 4'd0) begin
        ascii_s[23:16] = ASCII_SPACE;
        if (bcd_r[7:4] == 4'd0) begin
          ascii_s[15:8] = ASCII_SPACE;
        end else begin
          ascii_s[15:8] = nibble_to_ascii(bcd_r[7:4]);
        end
      end else begin
        ascii_s[23:16] = nibble_to_ascii(bcd_r[11:8]);
      end
    end else begin
      ascii_s[31:24] = nibble_to_ascii(bcd_r[15:12]);
    end
`else
    ascii_s[31:24] = nibble_to_ascii(bcd_r[15:12]);
`endif
  end

  // State register, datapath registers and the registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      bin_r   <= '0;
      bcd_r   <= '0;
      cnt_r   <= '0;
      ascii_r <= reset_word();
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          bin_r <= sat_s;
          bcd_r <= '0;
          cnt_r <= '0;
        end
        SHIFT: begin
          bcd_r <= shifted_s[BCD_W+BIN_W-1:BIN_W];
          bin_r <= shifted_s[BIN_W-1:0];
          cnt_r <= cnt_r + 4'd1;
        end
        DONE: begin
          ascii_r <= ascii_s;
        end
        default: begin
          bin_r <= '0;
          bcd_r <= '0;
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign ascii_out = ascii_r;

endmodule

// File: tb/tb_bcd_sv_ff.sv
// -----------------------------------------------------------------------------
// tb_bcd_sv_ff
// Self-checking bench for bcd_sv_ff. The stimulus process schedules each
// expected ascii_out value (with the edge at which it must appear) into a
// queue; the monitor samples ascii_out after every edge, switches to the next
// expected value when its edge is reached and compares every cycle, so both
// the update timing and the hold behaviour are covered. Expected values come
// from a decimal arithmetic reference model. Honours LEAD_ZERO_BLANK_EN.
// -----------------------------------------------------------------------------
module tb_bcd_sv_ff;

  logic        clk;
  logic        rst;
  logic [13:0] bin_in;
  logic [31:0] ascii_out;

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   cap    = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [31:0] RST_VAL = 32'h2020_2030;
`else
  localparam logic [31:0] RST_VAL = 32'h3030_3030;
`endif

  bcd_sv_ff #(.SAT_VALUE(9999)) dut (
    .clk       (clk),
    .rst       (rst),
    .bin_in    (bin_in),
    .ascii_out (ascii_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: saturate, split into decimal digits, render as ASCII.
  function automatic logic [31:0] ref_ascii(input int v);
    int          s;
    int          d;
    logic [31:0] r;
    s = (v > 9999) ? 9999 : v;
    r = 32'h0;
    d = 1;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = 8'h30 + 8'((s / d) % 10);
      d = d * 10;
    end
`ifdef LEAD_ZERO_BLANK_EN
    if (s < 1000) r[31:24] = 8'h20;
    if (s < 100)  r[23:16] = 8'h20;
    if (s < 10)   r[15:8]  = 8'h20;
`endif
    return r;
  endfunction

  // Entered at the negedge before the next rising edge; asserts rst for n edges.
  task automatic do_reset(input int n);
    rst = 1'b1;
    sb_q.delete();
    sb_q.push_back('{due: cyc + 1, val: RST_VAL});
    repeat (n) @(negedge clk);
    rst = 1'b0;
    cap = cyc + 1;
  endtask

  // Entered at negedge cyc == cap-1. mode 0: hold input, 1: random changes
  // during the conversion, 2: switch to mid_v during the conversion.
  task automatic convert(input int v, input int mode, input int mid_v);
    bin_in = 14'(v);
    sb_q.push_back('{due: cap + 15, val: ref_ascii(v)});
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i < 15) begin
        if (mode == 1) bin_in = 14'($urandom_range(0, 16383));
        else if (mode == 2 && i == 4) bin_in = 14'(mid_v);
      end
    end
    cap = cap + 16;
  endtask

  // Start a conversion and reset it on the 7th shift edge (capture + 7).
  task automatic convert_abort(input int v);
    bin_in = 14'(v);
    repeat (7) @(negedge clk);
    do_reset(1);
  endtask

  // Monitor / scoreboard.
  initial begin
    logic [31:0] exp_val;
    bit          exp_ok;
    exp_ok  = 1'b0;
    exp_val = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        if (sb_q[0].due == cyc) begin
          exp_val = sb_q[0].val;
          exp_ok  = 1'b1;
          void'(sb_q.pop_front());
        end else if (sb_q[0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL schedule cyc=%0d due=%0d got=%h exp=%h",
                   cyc, sb_q[0].due, ascii_out, sb_q[0].val);
          void'(sb_q.pop_front());
        end
      end
      if (exp_ok) begin
        checks++;
        if (ascii_out !== exp_val) begin
          errors++;
          $display("FAIL ascii_out cyc=%0d got=%h exp=%h", cyc, ascii_out, exp_val);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    bin_in = 14'd0;
    do_reset(3);

    // Zero held over repeated periods.
    convert(0, 0, 0);
    convert(0, 0, 0);
    convert(0, 0, 0);

    // 11, then changed to 243 during the conversion; next period shows 243.
    convert(11, 0, 0);
    convert(11, 2, 243);
    convert(243, 0, 0);

    // Saturation and digit boundaries.
    convert(9999, 0, 0);
    convert(16383, 0, 0);
    convert(10000, 0, 0);
    convert(9, 0, 0);
    convert(10, 0, 0);
    convert(99, 0, 0);
    convert(100, 0, 0);
    convert(999, 0, 0);
    convert(1000, 0, 0);

    // Abort mid-conversion: 1234's result must never appear.
    convert(5678, 0, 0);
    convert_abort(1234);
    convert(42, 0, 0);

    // Random values (including saturating ones) with random input churn.
    for (int i = 0; i < 300; i++) begin
      convert(int'($urandom_range(0, 16383)), int'($urandom_range(0, 1)), 0);
    end

    // Strided sweep across the whole in-range span.
    for (int v = 0; v <= 9999; v += 7) begin
      convert(v, 0, 0);
    end
    convert(9998, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
